// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter onto the single MIOC data/IO port.
// IDLE -> XFER -> ACK per access; round-robin or fixed master-0 priority on ties.
module mem_bus_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter bit          CPU_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_wr_i,
    input  logic [DATA_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_wr_i,
    input  logic [DATA_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              mem_ce_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] wt_data_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                sel_wr;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_xfer;

    assign sel_wr    = gnt_q ? m1_wr_i    : m0_wr_i;
    assign sel_addr  = gnt_q ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = gnt_q ? m1_wdata_i : m0_wdata_i;
    assign in_xfer   = (state_q == StXfer);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req_i || m1_req_i) begin
                    state_d = StXfer;
                    if (m0_req_i && m1_req_i) begin
                        gnt_d = CPU_PRIO ? 1'b0 : ~last_q;
                    end else begin
                        gnt_d = m1_req_i;
                    end
                end
            end
            StXfer: begin
                state_d = StAck;
                last_d  = gnt_q;
                if (gnt_q) begin
                    m1_ack_d = 1'b1;
                    if (!sel_wr) m1_rdata_d = rd_data_i;
                end else begin
                    m0_ack_d = 1'b1;
                    if (!sel_wr) m0_rdata_d = rd_data_i;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign mem_ce_o   = in_xfer;
    assign mem_wr_o   = in_xfer & sel_wr;
    assign mem_addr_o = in_xfer ? sel_addr  : '0;
    assign wt_data_o  = in_xfer ? sel_wdata : '0;
    assign busy_o     = (state_q != StIdle);
    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;

endmodule
